// File: rtl/in_fifo_pkg.sv
// Shared constants and helpers for the USB CDC IN-path byte FIFO.
package in_fifo_pkg;

  localparam int BYTE_W = 8;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/in_fifo_mem.sv
// Storage array for in_fifo: one synchronous write port, one asynchronous read port.
module in_fifo_mem
  import in_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = BYTE_W,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // Contents are intentionally not reset; the pointers alone define what is valid.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/in_fifo.sv
// First-word-fall-through byte FIFO between the application IN stream and USB CDC.
// Define IN_FIFO_LEVEL_EN to add the registered occupancy output level_o.
module in_fifo
  import in_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = BYTE_W,
  parameter int ADDR_WIDTH = ceil_log2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
`ifdef IN_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level_o
`endif
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  empty, full, push, pop;
  logic [DATA_WIDTH-1:0] rdata;

  // Extra MSB on each pointer separates full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign in_ready_o  = ~full;
  assign out_valid_o = ~empty;
  assign push        = in_valid_i & ~full;
  assign pop         = out_ready_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  in_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (in_data_i),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (rdata)
  );

  // Gated so the head reads as zero whenever nothing is stored, including after reset.
  assign out_data_o = empty ? '0 : rdata;

`ifdef IN_FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + PTR_ONE;
    else if (pop && !push) level_d = level_q - PTR_ONE;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) level_q <= '0;
    else         level_q <= level_d;
  end

  assign level_o = level_q;
`endif

endmodule

// File: tb/tb_in_fifo.sv
// Directed, table-driven bench for in_fifo configured with DEPTH=4.
module tb_in_fifo;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i;
`ifdef IN_FIFO_LEVEL_EN
  logic [2:0] level_o;
`endif

  int checks = 0;
  int errors = 0;

  in_fifo #(
    .DEPTH      (4),
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
`ifdef IN_FIFO_LEVEL_EN
    ,
    .level_o     (level_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       exp_ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_level;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_level(input string name, input int exp);
`ifdef IN_FIFO_LEVEL_EN
    check(name, {29'd0, level_o}, exp);
`else
    if (name.len() < 0 || exp < 0) $display("level %s unavailable", name);
`endif
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   in_cnt;
    int   out_cnt;
    logic push_now;

    // Row expectations describe the outputs seen before the edge that applies the row.
    vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    vecs[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 1};
    vecs[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 2};
    vecs[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 3};
    vecs[4] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 4};
    vecs[5] = '{1'b0, 8'h05, 1'b1, 1'b0, 1'b1, 8'h01, 4};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 3};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 2};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0};

    rstn_i      = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = 8'h00;
    out_ready_i = 1'b0;
    step();
    step();
    check("reset out_valid", out_valid_o, 1'b0);
    check("reset in_ready", in_ready_o, 1'b1);
    check("reset out_data", out_data_o, 8'h00);
    chk_level("reset level", 0);
    rstn_i = 1'b1;
    step();

    // Fill to full with the fifth byte held off, then drain in order.
    for (int i = 0; i < 10; i++) begin
      in_valid_i  = vecs[i].in_valid;
      in_data_i   = vecs[i].in_data;
      out_ready_i = vecs[i].out_ready;
      check($sformatf("tbl[%0d] in_ready", i), in_ready_o, vecs[i].exp_ready);
      check($sformatf("tbl[%0d] out_valid", i), out_valid_o, vecs[i].exp_valid);
      if (vecs[i].exp_valid)
        check($sformatf("tbl[%0d] out_data", i), out_data_o, vecs[i].exp_data);
      chk_level($sformatf("tbl[%0d] level", i), vecs[i].exp_level);
      step();
    end

    // One-cycle latency into an empty FIFO.
    in_valid_i  = 1'b1;
    in_data_i   = 8'hA5;
    out_ready_i = 1'b0;
    step();
    in_valid_i = 1'b0;
    check("latency out_valid", out_valid_o, 1'b1);
    check("latency out_data", out_data_o, 8'hA5);
    chk_level("latency level", 1);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("latency drained", out_valid_o, 1'b0);

    // Full with simultaneous push request and pop: only the pop happens.
    for (int k = 0; k < 4; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'h50 + 8'(k);
      step();
    end
    check("full in_ready", in_ready_o, 1'b0);
    chk_level("full level", 4);
    in_data_i   = 8'hAA;
    out_ready_i = 1'b1;
    check("fullpop head", out_data_o, 8'h50);
    step();
    check("fullpop in_ready", in_ready_o, 1'b1);
    check("fullpop next head", out_data_o, 8'h51);
    chk_level("fullpop level", 3);
    out_ready_i = 1'b0;
    step();
    in_valid_i = 1'b0;
    check("refill in_ready", in_ready_o, 1'b0);
    chk_level("refill level", 4);
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fulldrain[%0d]", k), out_data_o, (k == 3) ? 8'hAA : 8'h51 + 8'(k));
      step();
    end
    out_ready_i = 1'b0;
    check("fulldrain empty", out_valid_o, 1'b0);

    // Continuous streaming across several pointer wraps.
    in_cnt      = 0;
    out_cnt     = 0;
    in_valid_i  = 1'b1;
    in_data_i   = 8'h00;
    out_ready_i = 1'b1;
    for (int cyc = 0; cyc < 100 && out_cnt < 20; cyc++) begin
      if (out_valid_o) begin
        check($sformatf("stream[%0d]", out_cnt), out_data_o, out_cnt);
        out_cnt++;
      end
`ifdef IN_FIFO_LEVEL_EN
      if (cyc > 0) check("stream level<=1", level_o <= 3'd1, 1'b1);
`endif
      push_now = in_valid_i && in_ready_o;
      step();
      if (push_now) begin
        in_cnt++;
        if (in_cnt == 20) in_valid_i = 1'b0;
        else              in_data_i  = 8'(in_cnt);
      end
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    check("stream count", out_cnt, 20);
    check("stream empty", out_valid_o, 1'b0);

    // Asynchronous reset with entries stored, then a fresh push.
    for (int k = 0; k < 3; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'h11 * 8'(k + 1);
      step();
    end
    in_valid_i = 1'b0;
    check("midreset pre valid", out_valid_o, 1'b1);
    #2;
    rstn_i = 1'b0;
    #1;
    check("midreset out_valid", out_valid_o, 1'b0);
    check("midreset in_ready", in_ready_o, 1'b1);
    check("midreset out_data", out_data_o, 8'h00);
    chk_level("midreset level", 0);
    step();
    rstn_i     = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 8'h7E;
    step();
    in_valid_i = 1'b0;
    check("postreset out_valid", out_valid_o, 1'b1);
    check("postreset out_data", out_data_o, 8'h7E);
    chk_level("postreset level", 1);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("postreset drained", out_valid_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
